store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Store-side counterpart of the writeback load path. It takes SB/SH/SW requests from the MEM stage, aligns the register data into a 32-bit memory lane, and generates byte enables.
- Requests are queued in a small FIFO and drained to data memory over a write/ack handshake.
- The block flags misaligned stores, raises a load-hazard flag when a load targets a word with a pending store, and gives the pipeline back-pressure through o_store_ready.

Parameters:
- BITS_SIZE, 32, data width; fixed at 32 (4 byte lanes).
- ADDR_BITS, 32, byte-address width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_store_valid  input  1  store request this cycle.
- i_store_size  input  2  00 = byte, 01 = half, 11 = word, 10 = illegal.
- i_store_addr  input  ADDR_BITS  byte address.
- i_store_data  input  BITS_SIZE  rt register value, right-justified.
- o_store_ready  output  1  FIFO not full.
- o_misaligned  output  1  one-cycle pulse: the previous request was rejected.
- o_mem_write_en  output  1  write request to data memory.
- o_mem_addr  output  ADDR_BITS  word-aligned address (bits [1:0] = 00).
- o_mem_data  output  BITS_SIZE  lane-aligned write data.
- o_mem_byte_en  output  4  byte enables; bit n corresponds to data[8n+7:8n].
- i_mem_ack  input  1  memory accepted the current write.
- i_load_addr  input  ADDR_BITS  address of the load currently in MEM.
- o_load_hazard  output  1  combinational; the load word matches a pending store.
- o_empty  output  1  FIFO empty and no write in flight.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO pointers/count cleared; all pending stores discarded, including one mid-handshake.
  - State = IDLE.
  - Outputs: o_mem_write_en = 0, o_mem_addr = 0, o_mem_data = 0, o_mem_byte_en = 0, o_misaligned = 0, o_empty = 1, o_store_ready = 1.
- Alignment (combinational, before enqueue); a = addr[1:0]:
  - Byte: data = {4{d[7:0]}}, byte_en = 0001 << a.
  - Half: legal only if a[0] = 0. data = {2{d[15:0]}}, byte_en = 0011 if a[1] = 0, else 1100.
  - Word: legal only if a = 00. data = d, byte_en = 1111.
  - Size 10, or an illegal alignment → misaligned.
- Enqueue:
  - Accepted when i_store_valid && o_store_ready && !misaligned.
  - Entry stored = {addr with [1:0] forced to 00, aligned data, byte_en}.
  - A misaligned request is never enqueued. o_misaligned = 1 on the following cycle only, regardless of o_store_ready.
  - A valid request while o_store_ready = 0 is ignored; the pipeline must stall and hold it.
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits wide.
  - full = (count == DEPTH); o_store_ready = !full, derived from the registered count.
  - A push while full is rejected even if a pop happens in the same cycle.
  - Push and pop in the same cycle → count unchanged.
- Drain FSM, two states:
  - IDLE: o_mem_write_en = 0; i_mem_ack is ignored. If the FIFO is not empty: pop the head into the output registers, set o_mem_write_en = 1, go to WRITE. Latency from enqueue into an empty buffer to o_mem_write_en = 1 is 2 cycles.
  - WRITE: o_mem_addr, o_mem_data, o_mem_byte_en and o_mem_write_en are held stable until i_mem_ack = 1.
  - On ack with the FIFO not empty: pop the next head into the output registers the same edge and stay in WRITE. Back-to-back writes run one per ack cycle with no bubble.
  - On ack with the FIFO empty: go to IDLE; o_mem_write_en = 0 on the next cycle.
- Capacity: DEPTH queued plus 1 in flight.
- o_empty = (count == 0) && state == IDLE.
- o_load_hazard: 1 iff i_load_addr[ADDR_BITS-1:2] equals the word address of any valid FIFO entry, or of the in-flight register while in WRITE. Byte enables are not compared (conservative). The pipeline stalls the load while this is high.

Test Plan:
- Reset mid-WRITE (3 entries queued, no ack) → next cycle o_mem_write_en = 0, o_empty = 1, o_store_ready = 1; later acks have no effect.
- SB addr 0x1003, data 0x000000AB; ack held high → 2 cycles later: o_mem_addr 0x1000, o_mem_data 0xABABABAB, byte_en 1000; o_empty = 1 the cycle after the ack.
- SH addr 0x2002, data 0x1234, then SW addr 0x2004, data 0xDEADBEEF, ack always high → consecutive cycles show (0x2000, 0x12341234, 1100) then (0x2004, 0xDEADBEEF, 1111), with no bubble.
- SW to 0x3001; SH to 0x3003; size 10 to 0x3000 → o_misaligned pulses once after each; nothing is enqueued; o_empty stays 1.
- Ack held low, 5 stores pushed (DEPTH = 4) → 1 in flight + 4 queued; o_store_ready = 0; a 6th request is ignored; after one ack o_store_ready = 1 again.
- Store to 0x4008 pending with i_load_addr = 0x400B → o_load_hazard = 1. With i_load_addr = 0x400C → 0. After the ack retires the store → 0.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// rtl/store_write_buffer_if.sv - store request, memory write and load-hazard signal bundle
//
// Groups every non-clock/reset signal of store_write_buffer.
//   store request : i_store_valid, i_store_size, i_store_addr, i_store_data -> o_store_ready, o_misaligned
//   memory write  : o_mem_write_en, o_mem_addr, o_mem_data, o_mem_byte_en <- i_mem_ack
//   load check    : i_load_addr -> o_load_hazard
//   status        : o_empty
// master = pipeline/memory side, slave = the buffer.
interface store_write_buffer_if #(
    parameter int BITS_SIZE = 32,
    parameter int ADDR_BITS = 32
);
    logic                 i_store_valid;
    logic [1:0]           i_store_size;
    logic [ADDR_BITS-1:0] i_store_addr;
    logic [BITS_SIZE-1:0] i_store_data;
    logic                 o_store_ready;
    logic                 o_misaligned;
    logic                 o_mem_write_en;
    logic [ADDR_BITS-1:0] o_mem_addr;
    logic [BITS_SIZE-1:0] o_mem_data;
    logic [3:0]           o_mem_byte_en;
    logic                 i_mem_ack;
    logic [ADDR_BITS-1:0] i_load_addr;
    logic                 o_load_hazard;
    logic                 o_empty;

    modport master (
        output i_store_valid, i_store_size, i_store_addr, i_store_data, i_mem_ack, i_load_addr,
        input  o_store_ready, o_misaligned, o_mem_write_en, o_mem_addr, o_mem_data,
               o_mem_byte_en, o_load_hazard, o_empty
    );

    modport slave (
        input  i_store_valid, i_store_size, i_store_addr, i_store_data, i_mem_ack, i_load_addr,
        output o_store_ready, o_misaligned, o_mem_write_en, o_mem_addr, o_mem_data,
               o_mem_byte_en, o_load_hazard, o_empty
    );
endinterface

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - aligning store queue draining to data memory over write/ack
//
// Ports:
//   i_clock  - system clock, rising edge
//   i_reset  - asynchronous active-high reset
//   bus      - store_write_buffer_if.slave (store request, memory write, load hazard, status)
// SB/SH/SW requests are lane-aligned with byte enables, queued in a DEPTH-entry FIFO and
// written out one per ack. Misaligned requests are dropped and flagged a cycle later.
module store_write_buffer #(
    parameter int BITS_SIZE = 32,
    parameter int ADDR_BITS = 32,
    parameter int DEPTH     = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    store_write_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int WA_W  = ADDR_BITS - 2;
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    // Entries keep only the word address; the low two bits are always 00.
    logic [WA_W-1:0]      r_fifo_word [DEPTH];
    logic [BITS_SIZE-1:0] r_fifo_data [DEPTH];
    logic [3:0]           r_fifo_be   [DEPTH];

    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [0:0]           r_state;
    logic                 r_mem_we;
    logic [WA_W-1:0]      r_mem_word;
    logic [BITS_SIZE-1:0] r_mem_data;
    logic [3:0]           r_mem_be;
    logic                 r_misaligned;

    logic [PTR_W-1:0]     w_count;
    logic                 w_full;
    logic                 w_not_empty;
    logic [1:0]           w_lane;
    logic [BITS_SIZE-1:0] w_al_data;
    logic [3:0]           w_al_be;
    logic                 w_mis;
    logic                 w_push;
    logic                 w_pop;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [IDX_W-1:0]     w_slot;
    logic                 w_hazard;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == FULL_COUNT);
    assign w_not_empty = (w_count != '0);
    assign w_wr_idx    = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx    = r_rd_ptr[IDX_W-1:0];
    assign w_lane      = bus.i_store_addr[1:0];

    always_comb begin
        w_al_data = '0;
        w_al_be   = '0;
        w_mis     = 1'b0;
        case (bus.i_store_size)
            2'b00: begin
                w_al_data = {4{bus.i_store_data[7:0]}};
                w_al_be   = 4'b0001 << w_lane;
            end
            2'b01: begin
                w_al_data = {2{bus.i_store_data[15:0]}};
                w_al_be   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_mis     = w_lane[0];
            end
            2'b11: begin
                w_al_data = bus.i_store_data;
                w_al_be   = 4'b1111;
                w_mis     = (w_lane != 2'b00);
            end
            default: w_mis = 1'b1;
        endcase
    end

    // Fullness comes from the registered pointers, so a pop this cycle never frees room for a push.
    assign w_push = bus.i_store_valid && !w_full && !w_mis;
    // In WRITE the next head is only taken on the ack edge, giving one write per ack with no bubble.
    assign w_pop  = w_not_empty && ((r_state == S_IDLE) || bus.i_mem_ack);

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_fifo_word[w_wr_idx] <= bus.i_store_addr[ADDR_BITS-1:2];
            r_fifo_data[w_wr_idx] <= w_al_data;
            r_fifo_be[w_wr_idx]   <= w_al_be;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_mem_we     <= 1'b0;
            r_mem_word   <= '0;
            r_mem_data   <= '0;
            r_mem_be     <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= bus.i_store_valid && w_mis;
            if (w_pop) begin
                r_mem_word <= r_fifo_word[w_rd_idx];
                r_mem_data <= r_fifo_data[w_rd_idx];
                r_mem_be   <= r_fifo_be[w_rd_idx];
                r_mem_we   <= 1'b1;
                r_state    <= S_WRITE;
            end else if ((r_state == S_WRITE) && bus.i_mem_ack) begin
                r_mem_we <= 1'b0;
                r_state  <= S_IDLE;
            end
        end
    end

    // Word-granular match against every live entry plus the in-flight write; byte enables ignored.
    always_comb begin
        w_hazard = 1'b0;
        w_slot   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = w_rd_idx + IDX_W'(k);
            if ((PTR_W'(k) < w_count) && (r_fifo_word[w_slot] == bus.i_load_addr[ADDR_BITS-1:2])) begin
                w_hazard = 1'b1;
            end
        end
        if ((r_state == S_WRITE) && (r_mem_word == bus.i_load_addr[ADDR_BITS-1:2])) begin
            w_hazard = 1'b1;
        end
    end

    assign bus.o_store_ready  = !w_full;
    assign bus.o_misaligned   = r_misaligned;
    assign bus.o_mem_write_en = r_mem_we;
    assign bus.o_mem_addr     = {r_mem_word, 2'b00};
    assign bus.o_mem_data     = r_mem_data;
    assign bus.o_mem_byte_en  = r_mem_be;
    assign bus.o_load_hazard  = w_hazard;
    assign bus.o_empty        = !w_not_empty && (r_state == S_IDLE);
endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - scoreboard bench for store_write_buffer
module tb_store_write_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_write_buffer_if #(.BITS_SIZE(32), .ADDR_BITS(32)) bus ();

    store_write_buffer #(.BITS_SIZE(32), .ADDR_BITS(32), .DEPTH(DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int  n_cmp = 0;
    int  n_err = 0;

    wr_t exp_q[$];      // accepted, not yet acknowledged writes in order; [0] is in flight when m_busy
    bit  m_busy = 0;
    bit  m_mis  = 0;
    bit  stim_legal = 0;
    wr_t stim_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Alignment rules stated arithmetically: replication by multiplication, lane by modulo.
    function automatic bit model_align(input logic [1:0] size, input logic [31:0] addr,
                                       input logic [31:0] d, output wr_t w);
        int a;
        a = int'(addr % 32'd4);
        w.addr = addr - 32'(a);
        w.data = 32'h0;
        w.be   = 4'h0;
        case (size)
            2'b00: begin
                w.data = 32'(d[7:0]) * 32'h01010101;
                w.be   = 4'(1 << a);
                return 1'b1;
            end
            2'b01: begin
                if (a % 2 != 0) return 1'b0;
                w.data = 32'(d[15:0]) * 32'h00010001;
                w.be   = (a == 0) ? 4'b0011 : 4'b1100;
                return 1'b1;
            end
            2'b11: begin
                if (a != 0) return 1'b0;
                w.data = d;
                w.be   = 4'b1111;
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        bus.i_store_valid = 1'b1;
        bus.i_store_size  = size;
        bus.i_store_addr  = addr;
        bus.i_store_data  = data;
        stim_legal = model_align(size, addr, data, w);
        stim_w     = w;
    endtask

    task automatic drive_idle();
        bus.i_store_valid = 1'b0;
        stim_legal = 1'b0;
    endtask

    // Monitor/scoreboard: compares outputs mid-cycle, then advances the model across the coming edge.
    initial begin
        int  cnt;
        bit  hz;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_busy = 0;
                m_mis  = 0;
                check("rst_write_en", {31'd0, bus.o_mem_write_en}, 32'd0);
                check("rst_empty", {31'd0, bus.o_empty}, 32'd1);
                check("rst_ready", {31'd0, bus.o_store_ready}, 32'd1);
                continue;
            end
            cnt = exp_q.size() - (m_busy ? 1 : 0);
            check("write_en", {31'd0, bus.o_mem_write_en}, {31'd0, m_busy});
            if (m_busy && exp_q.size() > 0) begin
                check("mem_addr", bus.o_mem_addr, exp_q[0].addr);
                check("mem_data", bus.o_mem_data, exp_q[0].data);
                check("byte_en", {28'd0, bus.o_mem_byte_en}, {28'd0, exp_q[0].be});
            end
            check("store_ready", {31'd0, bus.o_store_ready}, (cnt < DEPTH) ? 32'd1 : 32'd0);
            check("empty", {31'd0, bus.o_empty}, (exp_q.size() == 0) ? 32'd1 : 32'd0);
            check("misaligned", {31'd0, bus.o_misaligned}, {31'd0, m_mis});
            hz = 0;
            foreach (exp_q[i]) if (exp_q[i].addr[31:2] == bus.i_load_addr[31:2]) hz = 1;
            check("load_hazard", {31'd0, bus.o_load_hazard}, {31'd0, hz});

            if (m_busy && bus.i_mem_ack) begin
                void'(exp_q.pop_front());
                m_busy = (cnt > 0);
            end else if (!m_busy) begin
                m_busy = (cnt > 0);
            end
            if (bus.i_store_valid && stim_legal && cnt < DEPTH) exp_q.push_back(stim_w);
            m_mis = bus.i_store_valid && !stim_legal;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_store_valid = 1'b0;
        bus.i_store_size  = 2'b00;
        bus.i_store_addr  = 32'h0;
        bus.i_store_data  = 32'h0;
        bus.i_mem_ack     = 1'b0;
        bus.i_load_addr   = 32'hFFFF_FFF0;
        repeat (2) tick();
        check("reset_addr", bus.o_mem_addr, 32'h0);
        check("reset_data", bus.o_mem_data, 32'h0);
        check("reset_be", {28'd0, bus.o_mem_byte_en}, 32'h0);
        check("reset_mis", {31'd0, bus.o_misaligned}, 32'd0);
        rst = 1'b0;
        tick();

        // SB to the top byte lane, ack held high
        bus.i_mem_ack = 1'b1;
        drive_store(2'b00, 32'h1003, 32'h0000_00AB);
        tick();
        drive_idle();
        tick();
        check("sb_we", {31'd0, bus.o_mem_write_en}, 32'd1);
        check("sb_addr", bus.o_mem_addr, 32'h1000);
        check("sb_data", bus.o_mem_data, 32'hABAB_ABAB);
        check("sb_be", {28'd0, bus.o_mem_byte_en}, 32'b1000);
        tick();
        check("sb_done_we", {31'd0, bus.o_mem_write_en}, 32'd0);
        check("sb_done_empty", {31'd0, bus.o_empty}, 32'd1);

        // SH then SW back to back, no bubble
        drive_store(2'b01, 32'h2002, 32'h0000_1234);
        tick();
        drive_store(2'b11, 32'h2004, 32'hDEAD_BEEF);
        tick();
        drive_idle();
        check("sh_addr", bus.o_mem_addr, 32'h2000);
        check("sh_data", bus.o_mem_data, 32'h1234_1234);
        check("sh_be", {28'd0, bus.o_mem_byte_en}, 32'b1100);
        tick();
        check("sw_we", {31'd0, bus.o_mem_write_en}, 32'd1);
        check("sw_addr", bus.o_mem_addr, 32'h2004);
        check("sw_data", bus.o_mem_data, 32'hDEAD_BEEF);
        check("sw_be", {28'd0, bus.o_mem_byte_en}, 32'b1111);
        tick();
        check("bb_done_we", {31'd0, bus.o_mem_write_en}, 32'd0);

        // misaligned requests
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive_store(2'b11, 32'h3001, 32'h1111_1111);
                1: drive_store(2'b01, 32'h3003, 32'h2222_2222);
                default: drive_store(2'b10, 32'h3000, 32'h3333_3333);
            endcase
            tick();
            drive_idle();
            check("mis_pulse", {31'd0, bus.o_misaligned}, 32'd1);
            check("mis_empty", {31'd0, bus.o_empty}, 32'd1);
            tick();
            check("mis_clear", {31'd0, bus.o_misaligned}, 32'd0);
            check("mis_no_write", {31'd0, bus.o_mem_write_en}, 32'd0);
        end

        // fill: 1 in flight + 4 queued, 6th ignored
        bus.i_mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_store(2'b11, 32'h6000 + 32'(i * 4), $urandom);
            tick();
        end
        check("full_ready", {31'd0, bus.o_store_ready}, 32'd0);
        check("full_we", {31'd0, bus.o_mem_write_en}, 32'd1);
        drive_store(2'b11, 32'h6100, 32'hBAD0_BAD0);
        tick();
        drive_idle();
        check("full_ready_hold", {31'd0, bus.o_store_ready}, 32'd0);
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        check("ready_after_ack", {31'd0, bus.o_store_ready}, 32'd1);
        bus.i_mem_ack = 1'b1;
        repeat (6) tick();
        check("drain_empty", {31'd0, bus.o_empty}, 32'd1);

        // load hazard
        bus.i_mem_ack = 1'b0;
        drive_store(2'b11, 32'h4008, 32'h5555_AAAA);
        tick();
        drive_idle();
        bus.i_load_addr = 32'h400B;
        #1;
        check("hz_queued", {31'd0, bus.o_load_hazard}, 32'd1);
        tick();
        check("hz_inflight", {31'd0, bus.o_load_hazard}, 32'd1);
        bus.i_load_addr = 32'h400C;
        #1;
        check("hz_other_word", {31'd0, bus.o_load_hazard}, 32'd0);
        bus.i_load_addr = 32'h400B;
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        check("hz_retired", {31'd0, bus.o_load_hazard}, 32'd0);

        // reset in the middle of a write with entries queued
        for (int i = 0; i < 3; i++) begin
            drive_store(2'b11, 32'h7000 + 32'(i * 4), $urandom);
            tick();
        end
        drive_idle();
        tick();
        check("pre_rst_we", {31'd0, bus.o_mem_write_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_we", {31'd0, bus.o_mem_write_en}, 32'd0);
        check("mid_rst_empty", {31'd0, bus.o_empty}, 32'd1);
        check("mid_rst_ready", {31'd0, bus.o_store_ready}, 32'd1);
        check("mid_rst_addr", bus.o_mem_addr, 32'h0);
        check("mid_rst_data", bus.o_mem_data, 32'h0);
        tick();
        rst = 1'b0;
        bus.i_mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_we", {31'd0, bus.o_mem_write_en}, 32'd0);
            check("post_rst_empty", {31'd0, bus.o_empty}, 32'd1);
        end

        // randomized traffic; the monitor checks every cycle
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1)
                drive_store(2'($urandom_range(0, 3)), 32'h5000 + 32'($urandom_range(0, 31)), $urandom);
            else
                drive_idle();
            bus.i_mem_ack   = ($urandom_range(0, 2) != 0);
            bus.i_load_addr = 32'h5000 + 32'($urandom_range(0, 31));
            tick();
        end
        drive_idle();
        bus.i_mem_ack = 1'b1;
        repeat (10) tick();
        check("final_empty", {31'd0, bus.o_empty}, 32'd1);
        check("final_model_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
